misc_stim_checker: RTL

Sequential stimulus driver and response checker for the `Misc` datapath: it generates pseudo-random A/B/C vectors, waits for the combinational outputs to settle, and checks XOUT2 against an internal reference model. It also compresses {XOUT1, XOUT2} into a signature register. It sits on the opposite side of the `Misc` ports, used in self-checking benches and on-chip BIST wrappers.

---
 rtl/misc_check_pkg.sv | 36 +++
 rtl/misc_lfsr16.sv | 38 +++
 rtl/misc_stim_checker.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/misc_check_pkg.sv
// Shared types and helper functions for the Misc stimulus driver / response checker.
package misc_check_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned REG_W  = 16;

    localparam logic [REG_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [REG_W-1:0] MISR_POLY = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    // Reference model of Misc.XOUT2: 8-bit wrapping A - B + C + 5.
    function automatic logic [DATA_W-1:0] xout2_model(input logic [DATA_W-1:0] a,
                                                      input logic [SEL_W-1:0]  b,
                                                      input logic [DATA_W-1:0] c);
        return DATA_W'(a - {4'b0000, b} + c + 8'd5);
    endfunction

    function automatic logic [REG_W-1:0] lfsr_step(input logic [REG_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    function automatic logic [REG_W-1:0] misr_step(input logic [REG_W-1:0] sig,
                                                   input logic [REG_W-1:0] data);
        return {sig[REG_W-2:0], 1'b0} ^ (sig[REG_W-1] ? MISR_POLY : '0) ^ data;
    endfunction

endpackage

// File: rtl/misc_lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous load and advance.
module misc_lfsr16
    import misc_check_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'h0001
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD,
    input  logic [15:0] SEED,
    input  logic        ADV,
    output logic [15:0] Q
);

    logic [REG_W-1:0] lfsr_q;
    logic [REG_W-1:0] lfsr_d;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (LOAD) begin
            lfsr_d = (SEED == '0) ? 16'h0001 : SEED;
        end else if (ADV) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign Q = lfsr_q;

endmodule

// File: rtl/misc_stim_checker.sv
// Drives pseudo-random A/B/C into Misc, checks XOUT2 against the reference model
// and compresses {XOUT1, XOUT2} into a MISR signature.
module misc_stim_checker
    import misc_check_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 64,
    parameter int unsigned SETTLE      = 1,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [7:0]  A,
    output logic [3:0]  B,
    output logic [7:0]  C,
    input  logic [7:0]  XOUT1,
    input  logic [7:0]  XOUT2,
    output logic [15:0] ERR_COUNT,
    output logic [15:0] SIGNATURE
);

    localparam logic [15:0] SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [15:0] ERR_MAX     = 16'hFFFF;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [SEL_W-1:0]    b_q, b_d;
    logic [DATA_W-1:0]   c_q, c_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [REG_W-1:0]    err_q, err_d;
    logic [REG_W-1:0]    sig_q, sig_d;
    logic [REG_W-1:0]    vcnt_q, vcnt_d;
    logic [3:0]          wait_q, wait_d;

    logic                lfsr_load;
    logic                lfsr_adv;
    logic [REG_W-1:0]    lfsr_val;
    logic [DATA_W-1:0]   exp_c;

    misc_lfsr16 #(
        .RESET_VAL (SEED_EFF)
    ) u_lfsr (
        .CLK  (CLK),
        .RST  (RST),
        .LOAD (lfsr_load),
        .SEED (SEED),
        .ADV  (lfsr_adv),
        .Q    (lfsr_val)
    );

    assign exp_c = xout2_model(a_q, b_q, c_q);

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        pass_d    = pass_q;
        err_d     = err_q;
        sig_d     = sig_q;
        vcnt_d    = vcnt_q;
        wait_d    = wait_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                lfsr_load = 1'b1;
                err_d     = '0;
                sig_d     = '0;
                vcnt_d    = '0;
                pass_d    = 1'b0;
                state_d   = ST_DRIVE;
            end
            ST_DRIVE: begin
                a_d     = lfsr_val[7:0];
                b_d     = lfsr_val[11:8];
                c_d     = lfsr_val[15:8];
                wait_d  = '0;
                state_d = (SETTLE != 0) ? ST_SETTLE : ST_CHECK;
            end
            ST_SETTLE: begin
                if (wait_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = 4'(wait_q + 4'd1);
                end
            end
            ST_CHECK: begin
                // Case inequality so an X/Z response is always an error.
                if ((XOUT2 !== exp_c) && (err_q != ERR_MAX)) begin
                    err_d = 16'(err_q + 16'd1);
                end
                sig_d    = misr_step(sig_q, {XOUT1, XOUT2});
                lfsr_adv = 1'b1;
                vcnt_d   = 16'(vcnt_q + 16'd1);
                state_d  = (vcnt_q == LAST_VEC) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            sig_q   <= '0;
            vcnt_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            sig_q   <= sig_d;
            vcnt_q  <= vcnt_d;
            wait_q  <= wait_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign C         = c_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_COUNT = err_q;
    assign SIGNATURE = sig_q;

endmodule
